stage_sequencer: RTL

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer with ready-handshake timeout.
// Optional stage skipping is selected by defining STAGE_SKIP_EN.
module stage_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             im_ready,
  input  logic             dm_ready,
  input  logic             halt,
  output logic             enable_fetch,
  output logic             enable_decode,
  output logic             enable_execute,
  output logic             enable_memaccess,
  output logic             enable_writeback,
  output logic [31:0]      present_instruction,
  output logic             do_dm_read,
  output logic             do_dm_write,
  output logic             do_reg_write,
  output logic             bus_error,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_XOR   = 6'h04;
  localparam logic [5:0] OP_SRLI  = 6'h05;
  localparam logic [5:0] OP_SLLI  = 6'h06;
  localparam logic [5:0] OP_ROTRI = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h09;
  localparam logic [5:0] OP_XORI  = 6'h0A;
  localparam logic [5:0] OP_MOVI  = 6'h0B;
  localparam logic [5:0] OP_LWI   = 6'h0C;
  localparam logic [5:0] OP_SWI   = 6'h0D;
  localparam logic [5:0] OP_TY_LS = 6'h0E;
  localparam logic [1:0] FN_LW    = 2'b00;
  localparam logic [1:0] FN_SW    = 2'b01;

  localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_ERR
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       mem_op;
  logic       rd_op;
  logic       wr_op;

  logic [5:0] op;
  logic [1:0] fn;
  logic       ls_lw;
  logic       ls_sw;
  logic       dec_mem;
  logic       dec_rd;
  logic       dec_wr;
  logic       wait_hit;
  logic       cnt_inc;
  logic       retire;
  state_t     after_exec;
  state_t     after_mem;

  // Opcode classification of the latched instruction
  always_comb begin
    op      = present_instruction[31:26];
    fn      = present_instruction[1:0];
    ls_lw   = (op == OP_TY_LS) && (fn == FN_LW);
    ls_sw   = (op == OP_TY_LS) && (fn == FN_SW);
    dec_mem = (op == OP_LWI) || (op == OP_SWI)
              || ls_lw || ls_sw;
    dec_rd  = (op == OP_LWI) || ls_lw;
    dec_wr  = ls_lw || (op inside {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SRLI, OP_SLLI, OP_ROTRI, OP_ADDI,
      OP_ORI, OP_XORI, OP_MOVI, OP_LWI});
  end

  // Stage routing after EXEC and MEM
  always_comb begin
`ifdef STAGE_SKIP_EN
    after_exec = mem_op ? S_MEM
               : (wr_op ? S_WB : S_FETCH);
    after_mem  = wr_op ? S_WB : S_FETCH;
`else
    after_exec = S_MEM;
    after_mem  = S_WB;
`endif
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    wait_hit  = (wait_cnt == WAIT_MAX);
    unique case (state)
      S_FETCH: begin
        if (!halt) begin
          if (im_ready)
            state_nxt = S_DECODE;
          else if (wait_hit)
            state_nxt = S_ERR;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = after_exec;
      S_MEM: begin
        if (!mem_op || dm_ready)
          state_nxt = after_mem;
        else if (wait_hit)
          state_nxt = S_ERR;
      end
      S_WB:     state_nxt = S_FETCH;
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_ERR;
    endcase
  end

  // Moore stage enables and stage-qualified strobes
  always_comb begin
    enable_fetch     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_memaccess = 1'b0;
    enable_writeback = 1'b0;
    do_dm_read       = 1'b0;
    do_dm_write      = 1'b0;
    do_reg_write     = 1'b0;
    bus_error        = 1'b0;
    unique case (1'b1)
      state == S_FETCH:  enable_fetch = ~halt;
      state == S_DECODE: enable_decode = 1'b1;
      state == S_EXEC:   enable_execute = 1'b1;
      state == S_MEM: begin
        enable_memaccess = 1'b1;
        do_dm_read       = mem_op & rd_op;
        do_dm_write      = mem_op & ~rd_op;
      end
      state == S_WB: begin
        enable_writeback = 1'b1;
        do_reg_write     = wr_op;
      end
      state == S_ERR:    bus_error = 1'b1;
      default:           bus_error = 1'b1;
    endcase
  end

  // Wait counter and retire event conditions
  always_comb begin
    cnt_inc = ((state == S_FETCH) && !im_ready)
           || ((state == S_MEM) && mem_op
               && !dm_ready);
    retire  = (state_nxt == S_FETCH)
           && ((state == S_EXEC) || (state == S_MEM)
               || (state == S_WB));
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= S_FETCH;
    else
      state <= state_nxt;
  end

  // Handshake wait counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if (state_nxt != state)
      wait_cnt <= '0;
    else if ((state == S_FETCH) && halt)
      wait_cnt <= '0;
    else if (cnt_inc)
      wait_cnt <= wait_cnt + 8'd1;
  end

  // Instruction latch at fetch completion
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      present_instruction <= '0;
    else if ((state == S_FETCH) && !halt && im_ready)
      present_instruction <= instruction;
  end

  // Operation class registered in DECODE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_op <= 1'b0;
      rd_op  <= 1'b0;
      wr_op  <= 1'b0;
    end else if (state == S_DECODE) begin
      mem_op <= dec_mem;
      rd_op  <= dec_rd;
      wr_op  <= dec_wr;
    end
  end

  // Retired instruction counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      retire_count <= '0;
    else if (retire)
      retire_count <= retire_count + 1'b1;
  end

endmodule
